// File: rtl/ir_decision_filter.sv
// Purpose : debounces per-period IR frequency decisions into a stable, confirmed target class.
// Latency : 2 cycles from the final done_in strobe to the updated target / target_changed pulse.
// Backpressure: none; every done_in produces a sample, back-to-back strobes included, and none is dropped.
//
// Ports:
//   clock          system clock, all logic on its rising edge
//   reset          synchronous active-high reset
//   done_in        one-cycle period-measurement strobe from the IR detector
//   decision_in    frequency class (0 none, 1..4 valid), valid the cycle after done_in
//   target         confirmed frequency class, 0 when not locked
//   target_valid   high while a target is locked
//   target_changed one-cycle pulse when target or target_valid changes
//   signal_lost    high while no done_in has arrived for TIMEOUT_CYCLES cycles
module ir_decision_filter #(
  parameter int CONFIRM_COUNT  = 4,
  parameter int MISS_LIMIT     = 3,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       done_in,
  input  logic [2:0] decision_in,
  output logic [2:0] target,
  output logic       target_valid,
  output logic       target_changed,
  output logic       signal_lost
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [2:0]  CONFIRM_W  = 3'(CONFIRM_COUNT);
  localparam logic [2:0]  MISS_W     = 3'(MISS_LIMIT);
  localparam logic [20:0] TIMEOUT_M1 = 21'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        done_d;
  logic [2:0]  candidate;
  logic [2:0]  streak;
  logic [2:0]  miss;
  logic [20:0] idle_cnt;

  logic        dec_ok;
  logic [2:0]  chal_streak;
  logic        chal_confirm;
  logic [2:0]  miss_inc;
  logic        miss_hit;
  logic        expire;

  // candidate always holds a valid class, so matching it implies a valid sample;
  // a mismatching valid sample restarts the streak at 1. A cleared streak with a
  // stale candidate gives 0+1 = 1, which is the same as a reload.
  always_comb begin
    dec_ok       = (decision_in >= 3'd1) && (decision_in <= 3'd4);
    chal_streak  = (decision_in == candidate) ? (streak + 3'd1) : 3'd1;
    chal_confirm = (chal_streak == CONFIRM_W);
    miss_inc     = miss + 3'd1;
    miss_hit     = (miss_inc == MISS_W);
    // Fires once, on the edge that takes the counter to TIMEOUT_CYCLES.
    // A coincident done_in wins and suppresses it.
    expire       = !done_in && (idle_cnt == TIMEOUT_M1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      done_d         <= 1'b0;
      candidate      <= 3'd0;
      streak         <= 3'd0;
      miss           <= 3'd0;
      idle_cnt       <= 21'd0;
      target         <= 3'd0;
      target_valid   <= 1'b0;
      target_changed <= 1'b0;
      signal_lost    <= 1'b0;
    end else begin
      done_d         <= done_in;
      target_changed <= 1'b0;

      if (done_in)
        idle_cnt <= 21'd0;
      else if (idle_cnt != '1)
        idle_cnt <= idle_cnt + 21'd1;

      if (done_in)
        signal_lost <= 1'b0;
      else if (expire)
        signal_lost <= 1'b1;

      // A sample can never coincide with expiry: the strobe that created it
      // cleared the idle counter one cycle earlier.
      if (expire) begin
        state          <= IDLE;
        candidate      <= 3'd0;
        streak         <= 3'd0;
        miss           <= 3'd0;
        target         <= 3'd0;
        target_valid   <= 1'b0;
        target_changed <= (state == LOCKED);
      end else if (done_d) begin
        case (state)
          IDLE: begin
            if (dec_ok) begin
              candidate <= decision_in;
              miss      <= 3'd0;
              if (CONFIRM_W == 3'd1) begin
                state          <= LOCKED;
                streak         <= 3'd0;
                target         <= decision_in;
                target_valid   <= 1'b1;
                target_changed <= 1'b1;
              end else begin
                state  <= ACQUIRE;
                streak <= 3'd1;
              end
            end
          end

          ACQUIRE: begin
            if (!dec_ok) begin
              state  <= IDLE;
              streak <= 3'd0;
            end else begin
              candidate <= decision_in;
              if (chal_confirm) begin
                state          <= LOCKED;
                streak         <= 3'd0;
                miss           <= 3'd0;
                target         <= decision_in;
                target_valid   <= 1'b1;
                target_changed <= 1'b1;
              end else begin
                streak <= chal_streak;
              end
            end
          end

          LOCKED: begin
            if (!dec_ok) begin
              streak <= 3'd0;
              if (miss_hit) begin
                state          <= IDLE;
                miss           <= 3'd0;
                target         <= 3'd0;
                target_valid   <= 1'b0;
                target_changed <= 1'b1;
              end else begin
                miss <= miss_inc;
              end
            end else if (decision_in == target) begin
              streak <= 3'd0;
              miss   <= 3'd0;
            end else begin
              // Challenger: switches target in place, never leaves LOCKED.
              miss      <= 3'd0;
              candidate <= decision_in;
              if (chal_confirm) begin
                streak         <= 3'd0;
                target         <= decision_in;
                target_changed <= 1'b1;
              end else begin
                streak <= chal_streak;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_decision_filter.sv
// Purpose : directed, table-driven self-checking bench for ir_decision_filter.
// Latency : outputs checked 1 time unit after the edge that processes each sample.
// Backpressure: none; the bench drives strobes at its own pace.
module tb_ir_decision_filter;

  localparam int T   = 300;   // scaled-down timeout for simulation length
  localparam int GAP = 100;   // strobe spacing, well inside the timeout

  logic       clock = 1'b0;
  logic       reset;
  logic       done_in;
  logic [2:0] decision_in;
  logic [2:0] target;
  logic       target_valid;
  logic       target_changed;
  logic       signal_lost;

  always #5 clock = ~clock;

  ir_decision_filter #(
    .CONFIRM_COUNT (4),
    .MISS_LIMIT    (3),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .done_in       (done_in),
    .decision_in   (decision_in),
    .target        (target),
    .target_valid  (target_valid),
    .target_changed(target_changed),
    .signal_lost   (signal_lost)
  );

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  always @(negedge clock)
    if (target_changed === 1'b1) pulse_cnt <= pulse_cnt + 1;

  typedef struct {
    logic [2:0] dec;
    logic [2:0] t;
    logic       v;
    logic       c;
  } vec_t;

  vec_t vecs[36];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Strobe, then present the decision on the sample cycle. Returns just after
  // the edge that processes the sample. Idle decision is an invalid class so a
  // sample taken on the wrong cycle shows up as a miss.
  task automatic send(input logic [2:0] dec);
    done_in = 1'b1;
    tick();
    done_in     = 1'b0;
    decision_in = dec;
    tick();
    decision_in = 3'd6;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
    $fatal(1);
  end

  initial begin
    int p0;

    // sample, expected target, valid, changed
    vecs[0]  = '{3'd3, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{3'd3, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{3'd3, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 3'd3, 1'b1, 1'b1};
    vecs[4]  = '{3'd2, 3'd3, 1'b1, 1'b0};
    vecs[5]  = '{3'd2, 3'd3, 1'b1, 1'b0};
    vecs[6]  = '{3'd3, 3'd3, 1'b1, 1'b0};
    vecs[7]  = '{3'd2, 3'd3, 1'b1, 1'b0};
    vecs[8]  = '{3'd2, 3'd3, 1'b1, 1'b0};
    vecs[9]  = '{3'd2, 3'd3, 1'b1, 1'b0};
    vecs[10] = '{3'd2, 3'd2, 1'b1, 1'b1};
    vecs[11] = '{3'd0, 3'd2, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 3'd2, 1'b1, 1'b0};
    vecs[13] = '{3'd2, 3'd2, 1'b1, 1'b0};
    vecs[14] = '{3'd0, 3'd2, 1'b1, 1'b0};
    vecs[15] = '{3'd5, 3'd2, 1'b1, 1'b0};
    vecs[16] = '{3'd6, 3'd0, 1'b0, 1'b1};
    vecs[17] = '{3'd1, 3'd0, 1'b0, 1'b0};
    vecs[18] = '{3'd1, 3'd0, 1'b0, 1'b0};
    vecs[19] = '{3'd4, 3'd0, 1'b0, 1'b0};
    vecs[20] = '{3'd4, 3'd0, 1'b0, 1'b0};
    vecs[21] = '{3'd0, 3'd0, 1'b0, 1'b0};
    vecs[22] = '{3'd4, 3'd0, 1'b0, 1'b0};
    vecs[23] = '{3'd4, 3'd0, 1'b0, 1'b0};
    vecs[24] = '{3'd4, 3'd0, 1'b0, 1'b0};
    vecs[25] = '{3'd4, 3'd4, 1'b1, 1'b1};
    vecs[26] = '{3'd1, 3'd4, 1'b1, 1'b0};
    vecs[27] = '{3'd1, 3'd4, 1'b1, 1'b0};
    vecs[28] = '{3'd0, 3'd4, 1'b1, 1'b0};
    vecs[29] = '{3'd1, 3'd4, 1'b1, 1'b0};
    vecs[30] = '{3'd1, 3'd4, 1'b1, 1'b0};
    vecs[31] = '{3'd1, 3'd4, 1'b1, 1'b0};
    vecs[32] = '{3'd1, 3'd1, 1'b1, 1'b1};
    vecs[33] = '{3'd0, 3'd1, 1'b1, 1'b0};
    vecs[34] = '{3'd0, 3'd1, 1'b1, 1'b0};
    vecs[35] = '{3'd0, 3'd0, 1'b0, 1'b1};

    // Reset with done_in held high: the strobe must be discarded.
    reset       = 1'b1;
    done_in     = 1'b1;
    decision_in = 3'd3;
    wait_n(3);
    check("reset target", target, 0);
    check("reset target_valid", target_valid, 0);
    check("reset target_changed", target_changed, 0);
    check("reset signal_lost", signal_lost, 0);
    reset   = 1'b0;
    done_in = 1'b0;
    tick();            // a leaked strobe would sample 3 here and lock one row early
    decision_in = 3'd6;

    for (int i = 0; i < 36; i++) begin
      send(vecs[i].dec);
      check($sformatf("vec%0d target", i), target, vecs[i].t);
      check($sformatf("vec%0d target_valid", i), target_valid, vecs[i].v);
      check($sformatf("vec%0d target_changed", i), target_changed, vecs[i].c);
      tick();
      check($sformatf("vec%0d pulse end", i), target_changed, 0);
    end

    // Spaced strobes: no pulse on strobes 1-3, exactly one on the 4th.
    p0 = pulse_cnt;
    for (int k = 0; k < 3; k++) begin
      send(3'd3);
      check($sformatf("spaced%0d target_valid", k), target_valid, 0);
      wait_n(GAP);
    end
    check("spaced no early pulse", pulse_cnt, p0);
    send(3'd3);
    check("spaced lock target", target, 3);
    check("spaced lock valid", target_valid, 1);
    check("spaced lock changed", target_changed, 1);
    wait_n(GAP);
    check("spaced one pulse", pulse_cnt, p0 + 1);

    // Back-to-back strobes: four consecutive samples of 4 switch the target.
    done_in     = 1'b1;
    decision_in = 3'd4;
    wait_n(4);
    check("b2b target before 4th", target, 3);
    done_in = 1'b0;
    tick();
    decision_in = 3'd6;
    check("b2b target", target, 4);
    check("b2b changed", target_changed, 1);

    // Timeout: last strobe edge S; signal lost on edge S+T.
    wait_n(T - 2);
    check("timeout early lost", signal_lost, 0);
    check("timeout early valid", target_valid, 1);
    tick();
    check("timeout lost", signal_lost, 1);
    check("timeout target", target, 0);
    check("timeout valid", target_valid, 0);
    check("timeout changed", target_changed, 1);
    tick();
    check("timeout pulse end", target_changed, 0);
    check("timeout lost held", signal_lost, 1);
    send(3'd4);
    check("recover lost", signal_lost, 0);
    check("recover no lock", target_valid, 0);

    // done_in on the exact expiry edge suppresses the timeout.
    for (int k = 0; k < 4; k++) send(3'd2);
    check("relock2 target", target, 2);
    wait_n(T - 2);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    check("edge lost", signal_lost, 0);
    check("edge valid", target_valid, 1);
    decision_in = 3'd2;
    tick();
    decision_in = 3'd6;
    check("edge target kept", target, 2);
    check("edge no pulse", target_changed, 0);
    wait_n(10);
    check("edge lost later", signal_lost, 0);

    // One-cycle reset while locked on 2.
    p0    = pulse_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst target", target, 0);
    check("rst valid", target_valid, 0);
    check("rst changed", target_changed, 0);
    check("rst lost", signal_lost, 0);
    tick();
    check("rst no pulse", pulse_cnt, p0);
    for (int k = 0; k < 3; k++) send(3'd2);
    check("rst partial relock", target_valid, 0);
    send(3'd2);
    check("rst relock target", target, 2);
    check("rst relock valid", target_valid, 1);
    check("rst relock changed", target_changed, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
